// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control codes, ALUOp codes and execute-unit FSM encoding.
// Imported by the iterative execute unit and its interface users.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND   = 4'd0;
    localparam logic [3:0] ALU_OR    = 4'd1;
    localparam logic [3:0] ALU_NAND  = 4'd2;
    localparam logic [3:0] ALU_NOR   = 4'd3;
    localparam logic [3:0] ALU_ADDU  = 4'd4;
    localparam logic [3:0] ALU_SUBU  = 4'd5;
    localparam logic [3:0] ALU_SLT   = 4'd6;
    localparam logic [3:0] ALU_EQUAL = 4'd7;
    localparam logic [3:0] ALU_SFT   = 4'd8;
    localparam logic [3:0] ALU_SFTV  = 4'd9;
    localparam logic [3:0] ALU_LUI   = 4'd10;

    localparam logic [2:0] OP_R_TYPE = 3'd0;
    localparam logic [2:0] OP_ADDI   = 3'd1;
    localparam logic [2:0] OP_SLTIU  = 3'd2;
    localparam logic [2:0] OP_BEQ    = 3'd3;
    localparam logic [2:0] OP_LUI    = 3'd4;
    localparam logic [2:0] OP_ORI    = 3'd5;
    localparam logic [2:0] OP_BNE    = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic is_shift(input logic [3:0] c);
        return (c == ALU_SFT) || (c == ALU_SFTV);
    endfunction

endpackage

// File: rtl/alu_iter_exec_if.sv
// Request/completion bundle between the ALU-control stage and the execute unit.
// The master issues operations, the slave (execute unit) reports completions.
interface alu_iter_exec_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [3:0]       ctrl_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [4:0]       shamt_i;
    logic             ready_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             illegal_o;

    modport master (
        output start_i, ctrl_i, src1_i, src2_i, shamt_i,
        input  ready_o, done_o, result_o, zero_o, illegal_o
    );

    modport slave (
        input  start_i, ctrl_i, src1_i, src2_i, shamt_i,
        output ready_o, done_o, result_o, zero_o, illegal_o
    );
endinterface

// File: rtl/alu_shift_step.sv
// One iteration of the shifter: arithmetic right shift by 0..STEP bits.
// Kept narrow so the per-cycle shift stays off the critical path.
module alu_shift_step #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [KW-1:0]    k_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = $signed(a_i) >>> k_i;

endmodule

// File: rtl/alu_iter_exec.sv
// Multi-cycle execute unit: single-cycle logic/arith ops, iterative
// arithmetic right shifts applying STEP bits per cycle.
module alu_iter_exec
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    alu_iter_exec_if.slave bus
);

    localparam int         KW    = $clog2(STEP + 1);
    localparam logic [4:0] STEP5 = 5'(STEP);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic             done_q, done_d;

    logic [4:0]       n_amt;
    logic [4:0]       k5;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] op_res;
    logic             op_ill;

    alu_shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .a_i (acc_q),
        .k_i (k),
        .y_o (acc_nxt)
    );

    assign k5 = (cnt_q < STEP5) ? cnt_q : STEP5;
    assign k  = KW'(k5);

    always_comb begin
        n_amt = (bus.ctrl_i == ALU_SFTV) ? bus.src1_i[4:0] : bus.shamt_i;
        op_ill = 1'b0;
        op_res = '0;
        case (bus.ctrl_i)
            ALU_AND:   op_res = bus.src1_i & bus.src2_i;
            ALU_OR:    op_res = bus.src1_i | bus.src2_i;
            ALU_NAND:  op_res = ~(bus.src1_i & bus.src2_i);
            ALU_NOR:   op_res = ~(bus.src1_i | bus.src2_i);
            ALU_ADDU:  op_res = bus.src1_i + bus.src2_i;
            ALU_SUBU:  op_res = bus.src1_i - bus.src2_i;
            ALU_SLT:   op_res = WIDTH'($signed(bus.src1_i) < $signed(bus.src2_i));
            ALU_EQUAL: op_res = WIDTH'(bus.src1_i == bus.src2_i);
            // Only reached with a zero shift amount.
            ALU_SFT,
            ALU_SFTV:  op_res = bus.src2_i;
            ALU_LUI:   op_res = {bus.src2_i[15:0], {(WIDTH-16){1'b0}}};
            default:   op_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;
        case (state_q)
            ST_SHIFT: begin
                acc_d = acc_nxt;
                cnt_d = cnt_q - k5;
                if (cnt_d == '0) begin
                    state_d   = ST_DONE;
                    result_d  = acc_nxt;
                    zero_d    = (acc_nxt == '0);
                    illegal_d = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (bus.start_i) begin
                    if (is_shift(bus.ctrl_i) && n_amt != '0) begin
                        acc_d   = bus.src2_i;
                        cnt_d   = n_amt;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d   = ST_DONE;
                        result_d  = op_res;
                        zero_d    = (op_res == '0);
                        illegal_d = op_ill;
                        done_d    = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
        end
    end

    assign bus.ready_o   = (state_q != ST_SHIFT);
    assign bus.done_o    = done_q;
    assign bus.result_o  = result_q;
    assign bus.zero_o    = zero_q;
    assign bus.illegal_o = illegal_q;

endmodule

// File: doc/alu_iter_exec.md
Name: alu_iter_exec

Overview:
Multi-cycle execute unit at the consumer end of the ALU-control interface. It accepts a 4-bit ALU control code plus operands from the ALU-control/decoder stage and produces the result. Logic ops, add/sub/compare and LUI complete in one cycle. SFT/SFTV shift iteratively, STEP bits per cycle, so a full barrel shifter is not on the critical path. It sits between the register-file read and the writeback mux of the multi-cycle CPU datapath.

Parameters:
WIDTH, 32, datapath width in bits
STEP, 1, shift bits applied per cycle; legal values are 1, 2, 4, 8

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous reset, active-high
start_i  input  1  request; accepted only when ready_o=1
ctrl_i  input  4  ALU control code
src1_i  input  WIDTH  operand 1 (rs); SFTV amount = src1_i[4:0]
src2_i  input  WIDTH  operand 2 (rt / immediate)
shamt_i  input  5  SFT shift amount
ready_o  output  1  unit can accept start_i this cycle
done_o  output  1  one-cycle pulse; result_o valid
result_o  output  WIDTH  result; held until the next completion
zero_o  output  1  result_o == 0; registered with result_o
illegal_o  output  1  last completed op used an undefined code (11-15)

Behaviour:
- Interface: single clock clk_i. rst_i is synchronous and active-high.
- Control codes: AND=0, OR=1, NAND=2, NOR=3, ADDU=4, SUBU=5, SLT=6 (signed less-than, result 1 or 0), EQUAL=7 (src1==src2 gives 1, else 0), SFT=8, SFTV=9, LUI=10 (result = {src2[15:0], 16'b0}).
- ADDU/SUBU wrap modulo 2^WIDTH. No overflow flag.
- SFT and SFTV shift src2 right arithmetically by N (sign bit replicated). N = shamt_i for SFT, src1_i[4:0] for SFTV.
- Reset: state=IDLE, result_o=0, zero_o=1, done_o=0, illegal_o=0, ready_o=1.
- FSM states are IDLE, SHIFT and DONE. ready_o = (state != SHIFT).
- IDLE or DONE, start_i=1 at cycle T:
  - Operands, ctrl and N are latched.
  - Non-shift op, or shift with N=0: next state is DONE with result_o written. done_o=1 in cycle T+1.
  - Shift with N>0: acc=src2, cnt=N, next state is SHIFT.
- SHIFT, each cycle:
  - acc shifts by k = min(STEP, cnt); cnt -= k.
  - When cnt reaches 0, result_o=acc and next state is DONE.
  - start_i is ignored in SHIFT; the request is not queued.
- Latency: 1 cycle for non-shift ops; 1 + ceil(N/STEP) cycles for shifts.
  - Examples: N=31, STEP=1 gives 32 cycles. N=31, STEP=8 gives 5 cycles.
- DONE lasts one cycle with done_o=1, then goes to IDLE. If start_i=1 in DONE it is accepted (back-to-back issue), so done_o can be high on consecutive cycles.
- Undefined codes 11-15: complete in 1 cycle with result_o=0, zero_o=1, illegal_o=1. illegal_o is cleared on the next legal completion.
- result_o, zero_o and illegal_o change only on the edge that enters DONE.
- rst_i mid-SHIFT: the operation is abandoned, all outputs return to reset values the next cycle, and done_o is never raised for the aborted op.

Decomposition:
- Package alu_ctrl_pkg holds:
  - 4-bit ALUCtrl localparams (AND through LUI);
  - 3-bit ALUOp codes (R_TYPE=0, ADDI=1, SLTIU=2, BEQ=3, LUI=4, ORI=5, BNE=6);
  - FSM state encoding.
- One sub-module, alu_shift_step: combinational arithmetic right shift of WIDTH bits by 0..STEP, used once per SHIFT cycle.

Test Plan:
- Reset: hold rst_i 2 cycles mid-activity, then release -> result_o=0, zero_o=1, done_o=0, ready_o=1, illegal_o=0.
- ADDU: src1=0xFFFFFFFF, src2=2 -> done_o at T+1, result_o=0x00000001, zero_o=0. SUBU with 5, 5 -> result_o=0, zero_o=1.
- SLT: src1=0x80000000, src2=1 -> result_o=1. EQUAL with 7, 7 -> 1. LUI with src2=0x1234ABCD -> 0xABCD0000.
- SFT, STEP=1: src2=0x80000000, shamt=4 -> ready_o=0 for 4 cycles, done_o at T+5, result_o=0xF8000000. start_i pulsed during SHIFT is ignored.
- SFTV: src1=0, src2=0x40 -> done_o at T+1, result=0x40. SFTV with src1=33 (amount 1) -> result_o=0x20. ctrl=12 -> result_o=0, illegal_o=1.
- Back-to-back issue: start_i asserted in the DONE cycle -> second done_o on the following cycle. Reset asserted mid-SHIFT -> no done_o for the aborted shift.
